// File: rtl/order_executor.sv
// Turns confirmed BUY/SELL decision levels into rate-limited orders on a valid/ready port,
// tracking net position, signed cash and trade count.
module order_executor #(
  parameter int unsigned PRICE_W      = 8,
  parameter int unsigned POS_W        = 4,
  parameter int unsigned MAX_POS      = 7,
  parameter int unsigned CASH_W       = 16,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned COOLDOWN_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     buy_sig,
  input  logic                     sell_sig,
  input  logic [PRICE_W-1:0]       price_in,
  input  logic                     order_ready,
  output logic                     order_valid,
  output logic                     order_side,
  output logic [PRICE_W-1:0]       order_price,
  output logic signed [POS_W-1:0]  position,
  output logic signed [CASH_W-1:0] cash,
  output logic [7:0]               trade_count,
  output logic                     busy
);

  localparam int unsigned HOLD_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);
  localparam int unsigned COOL_W = (COOLDOWN_CYC < 2) ? 1 : $clog2(COOLDOWN_CYC + 1);
  localparam logic signed [POS_W-1:0] POS_LIM = POS_W'(MAX_POS);
  localparam logic signed [POS_W-1:0] NEG_LIM = -POS_LIM;

  typedef enum logic [1:0] {IDLE, CONFIRM, ISSUE, COOLDOWN} state_t;

  state_t                     state, state_next;
  logic                       side, side_next;
  logic [HOLD_W-1:0]          hold_cnt, hold_next, hold_inc;
  logic [COOL_W-1:0]          cool_cnt, cool_next, cool_dec;
  logic                       order_valid_next, order_side_next, busy_next;
  logic [PRICE_W-1:0]         order_price_next;
  logic signed [POS_W-1:0]    position_next;
  logic signed [CASH_W-1:0]   cash_next;
  logic [7:0]                 trade_count_next;
  logic                       elig_buy, elig_sell;

  // Eligibility already folds in the position limit so the limit can never be overrun.
  assign elig_buy  = buy_sig && !sell_sig && (position < POS_LIM);
  assign elig_sell = sell_sig && !buy_sig && (position > NEG_LIM);
  assign hold_inc  = hold_cnt + HOLD_W'(1);
  assign cool_dec  = cool_cnt - COOL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      side        <= 1'b0;
      hold_cnt    <= '0;
      cool_cnt    <= '0;
      order_valid <= 1'b0;
      order_side  <= 1'b0;
      order_price <= '0;
      position    <= '0;
      cash        <= '0;
      trade_count <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      side        <= side_next;
      hold_cnt    <= hold_next;
      cool_cnt    <= cool_next;
      order_valid <= order_valid_next;
      order_side  <= order_side_next;
      order_price <= order_price_next;
      position    <= position_next;
      cash        <= cash_next;
      trade_count <= trade_count_next;
      busy        <= busy_next;
    end
  end

  always_comb begin
    state_next       = state;
    side_next        = side;
    hold_next        = hold_cnt;
    cool_next        = cool_cnt;
    order_valid_next = order_valid;
    order_side_next  = order_side;
    order_price_next = order_price;
    position_next    = position;
    cash_next        = cash;
    trade_count_next = trade_count;

    case (state)
      IDLE: begin
        if (elig_buy || elig_sell) begin
          side_next = elig_buy;
          hold_next = HOLD_W'(1);
          if (HOLD_CYC == 1) begin
            order_price_next = price_in;
            order_side_next  = elig_buy;
            order_valid_next = 1'b1;
            hold_next        = '0;
            state_next       = ISSUE;
          end else begin
            state_next = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (side ? elig_buy : elig_sell) begin
          hold_next = hold_inc;
          if (hold_inc == HOLD_W'(HOLD_CYC)) begin
            order_price_next = price_in;
            order_side_next  = side;
            order_valid_next = 1'b1;
            hold_next        = '0;
            state_next       = ISSUE;
          end
        end else begin
          hold_next  = '0;
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (order_ready) begin
          if (order_side) begin
            position_next = position + POS_W'(1);
            cash_next     = cash - CASH_W'(order_price);
          end else begin
            position_next = position - POS_W'(1);
            cash_next     = cash + CASH_W'(order_price);
          end
          trade_count_next = trade_count + 8'd1;
          order_valid_next = 1'b0;
          if (COOLDOWN_CYC == 0) begin
            state_next = IDLE;
          end else begin
            cool_next  = COOL_W'(COOLDOWN_CYC);
            state_next = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        cool_next = cool_dec;
        if (cool_dec == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_order_executor.sv
// Directed + randomized bench for order_executor against a transaction-level reference model.
module tb_order_executor;

  localparam int PW    = 8;
  localparam int MAXP  = 7;
  localparam int HOLD  = 2;
  localparam int COOL  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          buy_sig = 1'b0, sell_sig = 1'b0, order_ready = 1'b0;
  logic [PW-1:0] price_in = '0;
  logic          order_valid, order_side, busy;
  logic [PW-1:0] order_price;
  logic [3:0]    position;
  logic [15:0]   cash;
  logic [7:0]    trade_count;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a streak of identical eligible samples, a pending order, a cooldown timer.
  int          m_pos, m_cash, m_tc, m_cool, m_streak, m_sside, m_pend;
  logic [7:0]  m_price;
  logic        m_oside;

  order_executor #(
    .PRICE_W(PW), .POS_W(4), .MAX_POS(MAXP), .CASH_W(16),
    .HOLD_CYC(HOLD), .COOLDOWN_CYC(COOL)
  ) dut (
    .clk(clk), .rst(rst), .buy_sig(buy_sig), .sell_sig(sell_sig),
    .price_in(price_in), .order_ready(order_ready), .order_valid(order_valid),
    .order_side(order_side), .order_price(order_price), .position(position),
    .cash(cash), .trade_count(trade_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cash = 0; m_tc = 0; m_cool = 0; m_streak = 0; m_sside = 0; m_pend = 0;
    m_price = '0; m_oside = 1'b0;
  endtask

  task automatic model_edge(input logic b, input logic s, input logic [7:0] p, input logic r);
    int e;
    if (m_pend != 0) begin
      if (r) begin
        if (m_oside) begin m_pos++; m_cash -= int'(m_price); end
        else         begin m_pos--; m_cash += int'(m_price); end
        m_tc   = (m_tc + 1) % 256;
        m_pend = 0;
        m_cool = COOL;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      e = 0;
      if (b && !s && m_pos < MAXP)       e = 1;
      else if (s && !b && m_pos > -MAXP) e = 2;
      if (m_streak > 0 && e != m_sside) m_streak = 0;
      else if (e != 0) begin
        if (m_streak == 0) m_sside = e;
        m_streak++;
        if (m_streak >= HOLD) begin
          m_pend = 1; m_price = p; m_oside = (e == 1); m_streak = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [15:0] ec;
    logic [3:0]  ep;
    logic [7:0]  et;
    ec = m_cash[15:0];
    ep = m_pos[3:0];
    et = m_tc[7:0];
    chk("valid", 32'(order_valid), 32'(m_pend != 0));
    chk("side",  32'(order_side),  32'(m_oside));
    chk("price", 32'(order_price), 32'(m_price));
    chk("pos",   32'(position),    32'(ep));
    chk("cash",  32'(cash),        32'(ec));
    chk("count", 32'(trade_count), 32'(et));
    chk("busy",  32'(busy),        32'(m_pend != 0 || m_cool > 0 || m_streak > 0));
  endtask

  task automatic step(input logic b, input logic s, input logic [7:0] p, input logic r);
    buy_sig = b; sell_sig = s; price_in = p; order_ready = r;
    @(posedge clk);
    model_edge(b, s, p, r);
    #1;
    check_all();
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(order_valid), 32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    check_all();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic b, s;
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b0;

    // Basic buy
    step(1, 0, 8'h40, 1);
    step(1, 0, 8'h40, 1);
    chk("t2_valid", 32'(order_valid), 32'd1);
    chk("t2_side",  32'(order_side),  32'd1);
    chk("t2_price", 32'(order_price), 32'h40);
    step(0, 0, 8'h40, 1);
    chk("t2_valid_off", 32'(order_valid), 32'd0);
    chk("t2_pos",   32'(position),    32'd1);
    chk("t2_cash",  32'(cash),        32'h0000FFC0);
    chk("t2_count", 32'(trade_count), 32'd1);
    for (int i = 0; i < 15; i++) step(1, 0, 8'h11, 1);
    chk("t2_busy_last", 32'(busy), 32'd1);
    step(0, 0, 8'h11, 1);
    chk("t2_busy_done", 32'(busy), 32'd0);

    // Glitches: single-edge pulse, then both sides high
    step(1, 0, 8'h22, 1);
    step(0, 0, 8'h22, 1);
    step(0, 0, 8'h22, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 8'h22, 1);
    chk("t3_valid", 32'(order_valid), 32'd0);
    chk("t3_count", 32'(trade_count), 32'd1);

    // Backpressure
    step(1, 0, 8'h40, 0);
    step(1, 0, 8'h40, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h55, 0);
    chk("t4_valid", 32'(order_valid), 32'd1);
    chk("t4_price", 32'(order_price), 32'h40);
    step(0, 0, 8'h55, 1);
    chk("t4_count", 32'(trade_count), 32'd2);
    chk("t4_cash",  32'(cash),        32'h0000FF80);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h55, 1);

    // Reset in the middle of cooldown
    do_reset();
    chk("t1_pos", 32'(position), 32'd0);

    // Position limit
    for (int n = 0; n < 7; n++) begin
      step(1, 0, 8'h10, 1);
      step(1, 0, 8'h10, 1);
      step(1, 0, 8'h10, 1);
      for (int i = 0; i < COOL; i++) step(0, 0, 8'h10, 1);
    end
    chk("t5_pos",  32'(position), 32'd7);
    chk("t5_cash", 32'(cash),     32'h0000FF90);
    for (int i = 0; i < 20; i++) step(1, 0, 8'h33, 1);
    chk("t5_count", 32'(trade_count), 32'd7);
    chk("t5_busy",  32'(busy),        32'd0);
    step(0, 1, 8'h50, 1);
    step(0, 1, 8'h50, 1);
    chk("t5_sell_side", 32'(order_side), 32'd0);
    step(0, 0, 8'h50, 1);
    chk("t5_pos6",  32'(position), 32'd6);
    chk("t5_cash2", 32'(cash),     32'h0000FFE0);
    for (int i = 0; i < COOL; i++) step(0, 0, 8'h50, 1);

    // Reset while an order is pending
    step(1, 0, 8'h77, 0);
    step(1, 0, 8'h77, 0);
    chk("t6_valid", 32'(order_valid), 32'd1);
    do_reset();
    chk("t6_count", 32'(trade_count), 32'd0);
    chk("t6_cash",  32'(cash),        32'd0);

    // Randomized run: sticky decision levels, random price and sink readiness
    b = 1'b0; s = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0, 1:    begin b = 1'b1; s = 1'b0; end
          2, 3:    begin b = 1'b0; s = 1'b1; end
          4:       begin b = 1'b1; s = 1'b1; end
          default: begin b = 1'b0; s = 1'b0; end
        endcase
      end
      step(b, s, 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
